// File: rtl/arm_multicycle_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_defs_pkg
// Purpose  : Shared mux/ALU encodings, flag indices and immediate extender
//            for the multicycle ARM datapath.
// Revision : 1.0 - initial release
// ============================================================================
package arm_defs_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] SRCA_A  = 2'b00;
    localparam logic [1:0] SRCA_PC = 2'b01;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_STEP = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Branch offsets are word offsets, hence the sign-extend plus shift by 2.
    function automatic logic [31:0] extend_imm(input logic [1:0]  imm_src,
                                               input logic [23:0] imm);
        logic [31:0] ext;
        ext = '0;
        case (imm_src)
            IMM_8:   ext = {24'd0, imm[7:0]};
            IMM_12:  ext = {20'd0, imm[11:0]};
            IMM_24:  ext = {{6{imm[23]}}, imm, 2'b00};
            default: ext = '0;
        endcase
        return ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_multicycle_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : arm_dp_if
// Purpose  : Controller/memory strobes into the datapath and its results back.
// Revision : 1.0 - initial release
// ============================================================================
interface arm_dp_if;

    logic [31:0] ReadData;
    logic        PCWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;

    modport master (
        output ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
        input  Adr, WriteData, Instr, ALUFlags
    );

    modport slave (
        input  ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
        output Adr, WriteData, Instr, ALUFlags
    );

endinterface
`default_nettype wire

// File: rtl/arm_multicycle_datapath_regfile.sv
`default_nettype none
// ============================================================================
// Module   : arm_regfile
// Purpose  : R0..R14 with two read ports, one write port; R15 reads r15 input.
// Revision : 1.0 - initial release
// ============================================================================
module arm_regfile (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        we3,
    input  wire logic [3:0]  a1,
    input  wire logic [3:0]  a2,
    input  wire logic [3:0]  a3,
    input  wire logic [31:0] wd3,
    input  wire logic [31:0] r15,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2
);

    logic [31:0] rf_q [15];
    logic [31:0] rf_d [15];

    // Writes to R15 are dropped here; the PC is only loaded via PCWrite.
    always_comb begin
        rf_d = rf_q;
        if (we3 && (a3 != 4'd15)) begin
            rf_d[a3] = wd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Reads see the pre-write contents during a same-cycle write.
    always_comb begin
        rd1 = (a1 == 4'd15) ? r15 : rf_q[a1];
        rd2 = (a2 == 4'd15) ? r15 : rf_q[a2];
    end

endmodule
`default_nettype wire

// File: rtl/arm_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module   : arm_multicycle_datapath
// Purpose  : Multicycle ARM datapath: PC/IR/Data/A/WriteData/ALUOut, regfile,
//            extender and ALU, driven by the multicycle controller.
// Revision : 1.0 - initial release
// ============================================================================
module arm_multicycle_datapath
    import arm_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  wire logic clk,
    input  wire logic reset,
    arm_dp_if.slave   bus
);

    logic [31:0] pc_q,     pc_d;
    logic [31:0] instr_q,  instr_d;
    logic [31:0] data_q,   data_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] wd_q,     wd_d;
    logic [31:0] aluout_q, aluout_d;

    logic [31:0] ext_imm;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_b;
    logic [32:0] alu_sum;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_ovf;
    logic [3:0]  alu_flags;
    logic [31:0] result;
    logic [31:0] adr;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    always_comb begin
        ext_imm = extend_imm(bus.ImmSrc, instr_q[23:0]);
        src_a   = (bus.ALUSrcA == SRCA_PC) ? pc_q : a_q;
        src_b   = ext_imm;
        case (bus.ALUSrcB)
            SRCB_WD:   src_b = wd_q;
            SRCB_IMM:  src_b = ext_imm;
            SRCB_STEP: src_b = PC_STEP;
            SRCB_IMM2: src_b = ext_imm;
            default:   src_b = ext_imm;
        endcase
    end

    // Subtract is add of the inverted operand with carry-in, so C=1 means no borrow.
    always_comb begin
        alu_b      = (bus.ALUControl == ALU_SUB) ? ~src_b : src_b;
        alu_sum    = {1'b0, src_a} + {1'b0, alu_b}
                   + {32'd0, (bus.ALUControl == ALU_SUB)};
        alu_result = alu_sum[31:0];
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (bus.ALUControl)
            ALU_ADD, ALU_SUB: begin
                alu_result = alu_sum[31:0];
                alu_carry  = alu_sum[32];
                alu_ovf    = (src_a[31] == alu_b[31]) && (alu_sum[31] != src_a[31]);
            end
            ALU_AND: alu_result = src_a & src_b;
            ALU_ORR: alu_result = src_a | src_b;
            default: alu_result = alu_sum[31:0];
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_result[31];
        alu_flags[FLAG_Z] = (alu_result == 32'd0);
        alu_flags[FLAG_C] = alu_carry;
        alu_flags[FLAG_V] = alu_ovf;
    end

    always_comb begin
        case (bus.ResultSrc)
            RES_DATA:      result = data_q;
            RES_ALURESULT: result = alu_result;
            default:       result = aluout_q;
        endcase
        adr = bus.AdrSrc ? result : pc_q;
        ra1 = bus.RegSrc[0] ? 4'd15 : instr_q[19:16];
        ra2 = bus.RegSrc[1] ? instr_q[15:12] : instr_q[3:0];
    end

    // R15 reads return Result, which is PC+8 during decode.
    arm_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we3   (bus.RegWrite),
        .a1    (ra1),
        .a2    (ra2),
        .a3    (instr_q[15:12]),
        .wd3   (result),
        .r15   (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always_comb begin
        pc_d     = bus.PCWrite ? result : pc_q;
        instr_d  = bus.IRWrite ? bus.ReadData : instr_q;
        data_d   = bus.ReadData;
        a_d      = rd1;
        wd_d     = rd2;
        aluout_d = alu_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            data_q   <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            aluout_q <= aluout_d;
        end
    end

    assign bus.Adr       = adr;
    assign bus.WriteData = wd_q;
    assign bus.Instr     = instr_q;
    assign bus.ALUFlags  = alu_flags;

endmodule
`default_nettype wire

// File: doc/arm_multicycle_datapath.md
Name: arm_multicycle_datapath

Overview:
- Multicycle ARM datapath: the block that consumes every control strobe the multicycle controller issues and returns Instr[31:12] and ALUFlags to it.
- Holds PC, IR, Data, A, WriteData and ALUOut registers, the 15-entry register file, the immediate extender and the ALU.
- Drives the unified instruction/data memory through Adr and WriteData; ReadData returns from that memory.
- Sits between the controller and memory inside the top-level multicycle processor.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 32'd4, constant selected by ALUSrcB=2'b10

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
ReadData  in  32  memory read data
PCWrite  in  1  PC load enable
RegWrite  in  1  register file write enable
IRWrite  in  1  IR load enable
AdrSrc  in  1  0: Adr=PC, 1: Adr=Result
RegSrc  in  2  [0]: RA1 select, [1]: RA2 select
ALUSrcA  in  2  SrcA select
ALUSrcB  in  2  SrcB select
ResultSrc  in  2  Result select
ImmSrc  in  2  extender mode
ALUControl  in  2  ALU operation
Adr  out  32  memory address
WriteData  out  32  memory write data (B register)
Instr  out  32  IR contents; the controller uses [31:12]
ALUFlags  out  4  {N,Z,C,V} of the current ALU result, combinational

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and reset as named above.
- On reset:
  - PC=RESET_PC.
  - Instr, Data, A, WriteData, ALUOut = 0.
  - All R0..R14 = 0.
  - Adr=RESET_PC in the cycle after reset.
  - Reset has priority over every enable, including mid-instruction.
- Registers, all updated on the rising edge:
  - PC <= Result when PCWrite.
  - Instr <= ReadData when IRWrite.
  - Data, A, WriteData and ALUOut load every cycle with ReadData, RD1, RD2 and ALUResult respectively.
- Combinational datapath:
  - Adr = AdrSrc ? Result : PC.
  - RA1 = RegSrc[0] ? 4'd15 : Instr[19:16].
  - RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
  - Reading address 15 returns Result. In the decode step this is PC+8, because the controller presents PC+4 via ALUResult.
- Extender (ImmSrc):
  - 00: zero-extend Instr[7:0].
  - 01: zero-extend Instr[11:0].
  - 10: sign-extend Instr[23:0], shifted left by 2.
  - 11: 0.
- ALUSrcA: 00 A, 01 PC, 1x A.
- ALUSrcB: 00 WriteData, 01 ExtImm, 10 PC_STEP, 11 ExtImm.
- ALU, by ALUControl:
  - 00: add.
  - 01: sub (SrcA + ~SrcB + 1).
  - 10: and.
  - 11: orr.
- Flags:
  - N = result[31]; Z = (result == 0).
  - C = carry-out of the 33-bit sum for add/sub (sub yields C=1 when no borrow); C = 0 for logic operations.
  - V = signed overflow for add/sub; V = 0 for logic operations.
- ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult, 11 ALUOut.
- Register write: when RegWrite, WA3 = Instr[15:12] is written with Result. A write to address 15 is dropped; PC changes only via PCWrite.
- Simultaneous read and write of the same register: the read returns the old value. The write takes effect the next cycle.
- IRWrite and PCWrite in the same cycle, as in the fetch step: both load, and IR captures ReadData from the pre-update PC.
- Arithmetic wraps modulo 2^32: 32'hFFFF_FFFC + 4 gives 0, with C=1 and Z=1.

Decomposition:
- Shared package arm_defs_pkg holds the ALU_ADD/SUB/AND/ORR, RES_ALUOUT/DATA/ALURESULT, IMM_8/12/24 and SRCA_*/SRCB_* localparams.
- The package also holds the flag bit indices (N=3, Z=2, C=1, V=0).
- One sub-module, arm_regfile: 15x32 registers, two read ports and one write port, with the r15 input and synchronous reset.
- The ALU and extender stay inline.

Test Plan:
- Reset then fetch: hold reset 1 cycle, then PCWrite=1, IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ReadData=32'hE280_0005. Required: Adr=0 before the edge; afterwards PC=4, Adr=4, Instr=32'hE280_0005.
- Decode R15 read: after fetch, RegSrc=01, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Required: RD1=8 (PC+8), A=8 on the next edge.
- ADD immediate writeback: with R0=3 and Instr=E2801005, run ExecuteI (ImmSrc=00, ALUSrcB=01, ALUControl=00) then ALUWB (ResultSrc=00, RegWrite). Required: R1=8, ALUFlags=4'b0000.
- SUB flags: A=5, WriteData=5, ALUControl=01, ALUSrcA=00, ALUSrcB=00. Required: ALUFlags=4'b0110 (Z=1, C=1). With A=0, WriteData=1: required ALUFlags=4'b1000.
- Overflow and wrap: A=32'h7FFF_FFFF plus B=1. Required: flags 4'b1001. 32'hFFFF_FFFC + 4: required flags 4'b0110.
- LDR path and R15 write drop: AdrSrc=1 to ALUOut=32'h40, ReadData=32'hDEAD_BEEF, then ResultSrc=01 with RegWrite, Instr[15:12]=2. Required: R2=32'hDEAD_BEEF. Repeating with Instr[15:12]=15: required PC unchanged and no register modified.
